// File: rtl/font_rom_arbiter.sv
// ----------------------------------------------------------------------------
// font_rom_arbiter
//
// Shares one combinational font ROM between four requesters. A requester
// raises req[i] with its bank (req_ad), character (req_sel), start row
// (req_row) and burst length minus one (req_len). A round-robin arbiter
// grants one requester at a time. The winner then owns the ROM for len+1
// consecutive cycles, reading one row per cycle. Each row read comes back one
// cycle later on the rsp_* bus, tagged with the owner's one-hot rsp_valid bit.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-low
//   req[3:0]   : level requests, held until granted
//   req_ad     : 2-bit bank per requester,        requester i at [2i+1:2i]
//   req_sel    : 4-bit character per requester,   requester i at [4i+3:4i]
//   req_row    : 4-bit start row per requester,   requester i at [4i+3:4i]
//   req_len    : 4-bit length-1 per requester,    requester i at [4i+3:4i]
//   gnt[3:0]   : one-hot, one-cycle grant pulse
//   busy       : high while a burst owns the ROM
//   rom_ad/rom_sel/rom_row : registered address to the shared ROM
//   rom_data   : combinational ROM row for the current address
//   rsp_valid  : one-hot owner tag for rsp_data
//   rsp_data   : registered ROM row
//   rsp_row    : row index of rsp_data
//   rsp_last   : final row of a burst
// ----------------------------------------------------------------------------
module font_rom_arbiter #(
    parameter int          DATA_W   = 8,
    parameter logic [3:0]  IDLE_SEL = 4'd15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [7:0]        req_ad,
    input  logic [15:0]       req_sel,
    input  logic [15:0]       req_row,
    input  logic [15:0]       req_len,
    output logic [3:0]        gnt,
    output logic              busy,
    output logic [1:0]        rom_ad,
    output logic [3:0]        rom_sel,
    output logic [3:0]        rom_row,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_row,
    output logic              rsp_last
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          ptr_q,       ptr_d;
    logic [3:0]          gnt_q,       gnt_d;
    logic [1:0]          owner_q,     owner_d;
    logic [3:0]          len_q,       len_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic [1:0]          rom_ad_q,    rom_ad_d;
    logic [3:0]          rom_sel_q,   rom_sel_d;
    logic [3:0]          rom_row_q,   rom_row_d;
    logic [3:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic [3:0]          rsp_row_q,   rsp_row_d;
    logic                rsp_last_q,  rsp_last_d;

    // Round-robin search upward from pointer p. Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int j = 0; j < 4; j++) begin
            cand = p + 2'(j);
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [3:0]  eff_req;
    logic [2:0]  pick;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic        last_issue;
    logic [7:0]  ad_sh;
    logic [15:0] sel_sh;
    logic [15:0] row_sh;
    logic [15:0] len_sh;

    // A requester is still allowed to hold req during its own gnt cycle;
    // that cycle must not count as a fresh request.
    assign eff_req    = req & ~gnt_q;
    assign pick       = rr_pick(eff_req, ptr_q);
    assign pick_found = pick[2];
    assign pick_idx   = pick[1:0];
    assign last_issue = (state_q == BURST) && (cnt_q == len_q);

    // Field selection for the winning requester.
    assign ad_sh  = req_ad  >> {pick_idx, 1'b0};
    assign sel_sh = req_sel >> {pick_idx, 2'b00};
    assign row_sh = req_row >> {pick_idx, 2'b00};
    assign len_sh = req_len >> {pick_idx, 2'b00};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = 4'b0000;
        owner_d     = owner_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rom_ad_d    = rom_ad_q;
        rom_sel_d   = rom_sel_q;
        rom_row_d   = rom_row_q;
        rsp_valid_d = 4'b0000;
        rsp_data_d  = rsp_data_q;
        rsp_row_d   = rsp_row_q;
        rsp_last_d  = 1'b0;

        // Every BURST cycle issues one row; capture it for the response bus.
        if (state_q == BURST) begin
            rsp_valid_d = 4'b0001 << owner_q;
            rsp_data_d  = rom_data;
            rsp_row_d   = rom_row_q;
            rsp_last_d  = (cnt_q == len_q);
            if (cnt_q != len_q) begin
                cnt_d     = cnt_q + 4'd1;
                rom_row_d = rom_row_q + 4'd1;   // 15 -> 0 wrap is intended
            end
        end

        // Arbitrate in IDLE and at the end of the last row, so back-to-back
        // bursts need no idle bubble.
        if (state_q == IDLE || last_issue) begin
            if (pick_found) begin
                state_d   = BURST;
                gnt_d     = 4'b0001 << pick_idx;
                owner_d   = pick_idx;
                ptr_d     = pick_idx + 2'd1;
                len_d     = len_sh[3:0];
                cnt_d     = 4'd0;
                rom_ad_d  = ad_sh[1:0];
                rom_sel_d = sel_sh[3:0];
                rom_row_d = row_sh[3:0];
            end else begin
                state_d   = IDLE;
                rom_ad_d  = 2'd1;
                rom_sel_d = IDLE_SEL;
                rom_row_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            gnt_q       <= 4'b0000;
            owner_q     <= 2'd0;
            len_q       <= 4'd0;
            cnt_q       <= 4'd0;
            rom_ad_q    <= 2'd1;
            rom_sel_q   <= IDLE_SEL;
            rom_row_q   <= 4'd0;
            rsp_valid_q <= 4'b0000;
            rsp_data_q  <= '0;
            rsp_row_q   <= 4'd0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rom_ad_q    <= rom_ad_d;
            rom_sel_q   <= rom_sel_d;
            rom_row_q   <= rom_row_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_row_q   <= rsp_row_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == BURST);
    assign rom_ad    = rom_ad_q;
    assign rom_sel   = rom_sel_q;
    assign rom_row   = rom_row_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_row   = rsp_row_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for font_rom_arbiter: directed scenarios followed by randomized
// requests, fields and resets. A burst-level reference model predicts grants,
// ROM addresses and the response stream; responses go through a queue that an
// independent monitor drains.
// ----------------------------------------------------------------------------
module tb_font_rom_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req;
    logic [7:0]    req_ad;
    logic [15:0]   req_sel;
    logic [15:0]   req_row;
    logic [15:0]   req_len;
    logic [3:0]    gnt;
    logic          busy;
    logic [1:0]    rom_ad;
    logic [3:0]    rom_sel;
    logic [3:0]    rom_row;
    logic [DW-1:0] rom_data;
    logic [3:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_row;
    logic          rsp_last;

    font_rom_arbiter #(.DATA_W(DW), .IDLE_SEL(4'd15)) dut (
        .clk(clk), .reset(reset), .req(req), .req_ad(req_ad), .req_sel(req_sel),
        .req_row(req_row), .req_len(req_len), .gnt(gnt), .busy(busy),
        .rom_ad(rom_ad), .rom_sel(rom_sel), .rom_row(rom_row), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_row(rsp_row),
        .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [1:0] a, input logic [3:0] s,
                                             input logic [3:0] r);
        return ({6'd0, a} * 8'd67) ^ ({4'd0, s} * 8'd13) ^ ({4'd0, r} * 8'd29) ^ 8'h5A;
    endfunction

    assign rom_data = rom_fn(rom_ad, rom_sel, rom_row);

    typedef struct packed {
        logic [3:0]    vld;
        logic [DW-1:0] data;
        logic [3:0]    row;
        logic          last;
    } rsp_t;

    rsp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (burst level) ----------------
    bit m_busy = 0;
    int m_owner = 0, m_ptr = 0, m_k = 0, m_len = 0, m_start = 0, m_ad = 0, m_sel = 0;
    logic [3:0] m_gnt = 4'b0;
    bit m_rst = 0;

    always @(posedge clk) begin
        bit   arb;
        int   w;
        logic [3:0] cand;
        rsp_t e;
        if (!reset) begin
            m_busy = 0; m_ptr = 0; m_gnt = 4'b0; m_rst = 1;
            exp_q.delete();
        end else begin
            m_rst = 0;
            arb = !m_busy;
            if (m_busy) begin
                e.vld  = 4'(1 << m_owner);
                e.row  = 4'((m_start + m_k) % 16);
                e.data = rom_fn(2'(m_ad), 4'(m_sel), e.row);
                e.last = (m_k == m_len);
                exp_q.push_back(e);
                if (m_k == m_len) arb = 1;
                else m_k++;
            end
            if (arb) begin
                cand = req & ~m_gnt;
                w = -1;
                for (int j = 0; j < 4; j++)
                    if (w < 0 && cand[(m_ptr + j) % 4]) w = (m_ptr + j) % 4;
                if (w >= 0) begin
                    m_busy  = 1;
                    m_owner = w;
                    m_ptr   = (w + 1) % 4;
                    m_ad    = int'((req_ad  >> (2 * w)) & 8'h3);
                    m_sel   = int'((req_sel >> (4 * w)) & 16'hF);
                    m_start = int'((req_row >> (4 * w)) & 16'hF);
                    m_len   = int'((req_len >> (4 * w)) & 16'hF);
                    m_k     = 0;
                    m_gnt   = 4'(1 << w);
                end else begin
                    m_busy = 0;
                    m_gnt  = 4'b0;
                end
            end else begin
                m_gnt = 4'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [1:0] ead;
        logic [3:0] esel, erow;
        rsp_t e;
        #1;
        checks++;
        if (gnt !== m_gnt) begin
            failures++; $display("FAIL gnt got=%b exp=%b t=%0t", gnt, m_gnt, $time);
        end
        checks++;
        if (busy !== m_busy) begin
            failures++; $display("FAIL busy got=%b exp=%b t=%0t", busy, m_busy, $time);
        end
        ead  = m_busy ? 2'(m_ad) : 2'd1;
        esel = m_busy ? 4'(m_sel) : 4'd15;
        erow = m_busy ? 4'((m_start + m_k) % 16) : 4'd0;
        checks++;
        if ({rom_ad, rom_sel, rom_row} !== {ead, esel, erow}) begin
            failures++;
            $display("FAIL rom_addr got=%h/%h/%h exp=%h/%h/%h t=%0t",
                     rom_ad, rom_sel, rom_row, ead, esel, erow, $time);
        end
        if (m_rst) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_row, rsp_last} !== '0) begin
                failures++;
                $display("FAIL reset_rsp got=%b/%h/%h/%b exp=0 t=%0t",
                         rsp_valid, rsp_data, rsp_row, rsp_last, $time);
            end
        end
        checks++;
        if ($countones(rsp_valid) > 1) begin
            failures++; $display("FAIL rsp_onehot got=%b exp=onehot t=%0t", rsp_valid, $time);
        end
        if (rsp_valid != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got=%b exp=none t=%0t", rsp_valid, $time);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_valid, rsp_data, rsp_row, rsp_last} !== e) begin
                    failures++;
                    $display("FAIL rsp got=%b/%h/%h/%b exp=%b/%h/%h/%b t=%0t",
                             rsp_valid, rsp_data, rsp_row, rsp_last,
                             e.vld, e.data, e.row, e.last, $time);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++; failures++;
            e = exp_q.pop_front();
            $display("FAIL rsp_missing got=none exp=%b/%h/%h/%b t=%0t",
                     e.vld, e.data, e.row, e.last, $time);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drop_granted();
        for (int i = 0; i < 4; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic set_fields(input int i, input int ad, input int sel, input int row,
                              input int len);
        req_ad[2*i +: 2]  = 2'(ad);
        req_sel[4*i +: 4] = 4'(sel);
        req_row[4*i +: 4] = 4'(row);
        req_len[4*i +: 4] = 4'(len);
    endtask

    initial begin
        reset = 1'b0; req = '0; req_ad = '0; req_sel = '0; req_row = '0; req_len = '0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Single request; sel changed during the gnt cycle must not leak in.
        set_fields(0, 3, 6, 2, 3);
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt[0]) begin req[0] = 1'b0; req_sel[3:0] = 4'd9; end
        end

        // Full contention, single-row bursts.
        for (int i = 0; i < 4; i++) set_fields(i, i, i + 1, i + 4, 0);
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin step(); drop_granted(); end

        // Round-robin wrap: grant 2, then 0 and 2 together.
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin step(); drop_granted(); end
        req = 4'b0101;
        for (int c = 0; c < 6; c++) begin step(); drop_granted(); end

        // Row wrap 14,15,0,1.
        set_fields(1, 2, 5, 14, 3);
        req = 4'b0010;
        for (int c = 0; c < 8; c++) begin step(); drop_granted(); end

        // Reset in the middle of a long burst, then pointer restarts at 0.
        set_fields(3, 1, 7, 0, 7);
        req = 4'b1000;
        for (int c = 0; c < 6 && !gnt[3]; c++) step();
        req = 4'b0000;
        step(); step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_fields(1, 0, 3, 8, 1);
        set_fields(3, 3, 3, 3, 0);
        req = 4'b1010;
        for (int c = 0; c < 8; c++) begin step(); drop_granted(); end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (reset == 1'b0) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 2) == 0)
                    set_fields(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 15)),
                               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                           : int'($urandom_range(0, 3)));
            end
        end

        req = '0;
        repeat (40) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
